// File: rtl/snn_tick_scheduler.sv
// Timestep sequencer: issues tick pulses at a programmable period, waits for grid_done
// between ticks, counts timesteps and flags overrun / grid fault.
module snn_tick_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int STEP_W   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [STEP_W-1:0]   cfg_num_steps,
  input  logic                grid_done,
  input  logic                grid_error,
  output logic                tick,
  output logic                busy,
  output logic [STEP_W-1:0]   step_count,
  output logic                finished,
  output logic                overrun,
  output logic                fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_TICK, S_WAIT_DONE, S_WAIT_PERIOD, S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic [STEP_W-1:0]   num_q, num_d;
  logic [STEP_W-1:0]   step_q, step_d, step_inc;
  logic                stop_pend_q, stop_pend_d;
  logic                overrun_q, overrun_d;
  logic                fault_q, fault_d;
  logic                tick_q, busy_q, finished_q;

  // Expiry is judged on the post-decrement value so a done on the last
  // period cycle still yields exactly P cycles between ticks.
  assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
  assign step_inc = step_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    step_d      = step_q;
    stop_pend_d = stop_pend_q;
    overrun_d   = overrun_q;
    fault_d     = fault_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          period_d    = (cfg_period < PERIOD_W'(2)) ? PERIOD_W'(2) : cfg_period;
          num_d       = cfg_num_steps;
          step_d      = '0;
          overrun_d   = 1'b0;
          fault_d     = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = S_TICK;
        end
      end
      S_TICK: begin
        cnt_d = period_q - 1'b1;
        if (stop) stop_pend_d = 1'b1;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_dec;
        if (stop) stop_pend_d = 1'b1;
        if (grid_done) begin
          step_d = step_inc;
          if (stop_pend_q || stop || (num_q != '0 && step_inc == num_q))
            state_d = S_FINISH;
          else if (cnt_dec == '0)
            state_d = S_TICK;
          else
            state_d = S_WAIT_PERIOD;
        end else if (cnt_dec == '0) begin
          overrun_d = 1'b1;
        end
      end
      S_WAIT_PERIOD: begin
        cnt_d = cnt_dec;
        if (stop)                state_d = S_FINISH;
        else if (cnt_dec == '0)  state_d = S_TICK;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Grid fault ends the run and wins over done/stop; FINISH is excluded so a
    // sticky error cannot hold the sequencer there forever.
    if (grid_error && state_q != S_IDLE && state_q != S_FINISH) begin
      fault_d = 1'b1;
      step_d  = step_q;
      state_d = S_FINISH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      period_q    <= PERIOD_W'(2);
      cnt_q       <= '0;
      num_q       <= '0;
      step_q      <= '0;
      stop_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      fault_q     <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      step_q      <= step_d;
      stop_pend_q <= stop_pend_d;
      overrun_q   <= overrun_d;
      fault_q     <= fault_d;
      tick_q      <= (state_d == S_TICK);
      busy_q      <= (state_d != S_IDLE);
      finished_q  <= (state_d == S_FINISH);
    end
  end

  assign tick       = tick_q;
  assign busy       = busy_q;
  assign step_count = step_q;
  assign finished   = finished_q;
  assign overrun    = overrun_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_snn_tick_scheduler.sv
// Bench for snn_tick_scheduler: timeline model of tick/finish cycles checked every
// cycle, plus hand-computed tick/finish cycle pins for directed runs.
module tb_snn_tick_scheduler;
  localparam int PW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset_n, start, stop, grid_error;
  logic [PW-1:0] cfg_period;
  logic [SW-1:0] cfg_num_steps;
  logic          grid_done, g_auto, g_man;
  logic          tick, busy, finished, overrun, fault;
  logic [SW-1:0] step_count;

  assign grid_done = g_auto | g_man;

  snn_tick_scheduler #(.PERIOD_W(PW), .STEP_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .cfg_period(cfg_period), .cfg_num_steps(cfg_num_steps),
    .grid_done(grid_done), .grid_error(grid_error),
    .tick(tick), .busy(busy), .step_count(step_count),
    .finished(finished), .overrun(overrun), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Grid responder: done pulse lat cycles after each observed tick
  int lat = 1, done_cyc = -1;
  bit auto_en = 1'b0;
  always @(posedge clk) begin
    #1;
    g_auto = auto_en && (cyc == done_cyc);
  end

  // Timeline model: absolute cycles of the next tick / finish pulse
  bit m_run, m_wait, m_sp, m_ovr, m_flt;
  int m_P, m_N, m_steps, m_last, m_tick_at, m_fin_at;

  task automatic m_reset();
    m_run = 0; m_wait = 0; m_sp = 0; m_ovr = 0; m_flt = 0;
    m_steps = 0; m_tick_at = -1; m_fin_at = -1; m_last = 0; m_P = 2; m_N = 0;
  endtask

  task automatic m_update(int c);
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_P = (cfg_period < 2) ? 2 : int'(cfg_period); m_N = int'(cfg_num_steps);
        m_steps = 0; m_ovr = 0; m_flt = 0; m_sp = 0; m_wait = 0;
        m_tick_at = c + 1; m_fin_at = -1;
      end
    end else if (c == m_fin_at) begin
      m_run = 0; m_fin_at = -1; m_tick_at = -1;
    end else if (grid_error) begin
      m_flt = 1; m_fin_at = c + 1; m_tick_at = -1; m_wait = 0;
    end else if (c == m_tick_at) begin
      m_last = c; m_wait = 1; m_tick_at = -1;
      if (stop) m_sp = 1;
    end else if (m_wait) begin
      if (grid_done) begin
        m_steps = (m_steps + 1) % (1 << SW); m_wait = 0;
        if (m_sp || stop || (m_N != 0 && m_steps == m_N)) m_fin_at = c + 1;
        else m_tick_at = (m_last + m_P > c + 1) ? m_last + m_P : c + 1;
      end else begin
        if (stop) m_sp = 1;
        if (c >= m_last + m_P - 1) m_ovr = 1;
      end
    end else if (stop) begin
      m_fin_at = c + 1; m_tick_at = -1;
    end
  endtask

  int ticks[$];
  int fin_cyc = -1, fin_cnt = 0, ovr_first = -1;

  // Single compare process: checks outputs against the model every cycle
  always @(negedge clk) begin
    if (!reset_n) m_reset();
    chk("tick",       int'(tick),       int'(m_run && cyc == m_tick_at));
    chk("busy",       int'(busy),       int'(m_run));
    chk("finished",   int'(finished),   int'(m_run && cyc == m_fin_at));
    chk("step_count", int'(step_count), m_steps);
    chk("overrun",    int'(overrun),    int'(m_ovr));
    chk("fault",      int'(fault),      int'(m_flt));
    if (tick) begin ticks.push_back(cyc); done_cyc = cyc + lat; end
    if (finished) begin fin_cyc = cyc; fin_cnt++; end
    if (overrun && ovr_first < 0) ovr_first = cyc;
    if (reset_n) m_update(cyc);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_to(int target);
    while (cyc < target) step();
  endtask

  task automatic wait_fin(string nm, int budget);
    int n0 = fin_cnt;
    for (int k = 0; k < budget && fin_cnt == n0; k++) step();
    if (fin_cnt == n0) chk({nm, "_timeout"}, 0, 1);
    step(); step();
  endtask

  // Configure, clear trackers and pulse start; returns start cycle
  task automatic launch(input int p, input int n, input int l, output int s);
    cfg_period = PW'(p); cfg_num_steps = SW'(n); lat = l; auto_en = 1'b1;
    ticks.delete(); ovr_first = -1; fin_cyc = -1;
    s = cyc; start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic chk_ticks(string nm, int s, int n, int o0, int o1, int o2);
    chk({nm, "_nticks"}, ticks.size(), n);
    if (ticks.size() == n) begin
      if (n > 0) chk({nm, "_tick0"}, ticks[0] - s, o0);
      if (n > 1) chk({nm, "_tick1"}, ticks[1] - s, o1);
      if (n > 2) chk({nm, "_tick2"}, ticks[2] - s, o2);
    end
  endtask

  int s;
  initial begin
    m_reset();
    reset_n = 1'b0; start = 0; stop = 0; grid_error = 0; g_man = 0;
    cfg_period = '0; cfg_num_steps = '0;
    step(); step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_step", int'(step_count), 0);
    reset_n = 1'b1; step();

    // Bounded run: P=10, N=3, done 4 after tick
    launch(10, 3, 4, s);
    wait_fin("bounded", 60);
    chk_ticks("bounded", s, 3, 1, 11, 21);
    chk("bounded_fin", fin_cyc - s, 26);
    chk("bounded_steps", int'(step_count), 3);
    chk("bounded_ovr", int'(overrun), 0);

    // Overrun: P=5, done 8 after tick
    launch(5, 3, 8, s);
    wait_fin("overrun", 60);
    chk_ticks("overrun", s, 3, 1, 10, 19);
    chk("overrun_first", ovr_first - s, 6);
    chk("overrun_flag", int'(overrun), 1);
    chk("overrun_fin", fin_cyc - s, 28);

    // Stop in WAIT_PERIOD after step 2
    launch(6, 0, 2, s);
    wait_to(s + 11); stop = 1'b1; step(); stop = 1'b0;
    wait_fin("stop_wp", 20);
    chk_ticks("stop_wp", s, 2, 1, 7, 0);
    chk("stop_wp_fin", fin_cyc - s, 12);
    chk("stop_wp_steps", int'(step_count), 2);

    // Stop in WAIT_DONE of step 3
    launch(6, 0, 4, s);
    wait_to(s + 15); stop = 1'b1; step(); stop = 1'b0;
    wait_fin("stop_wd", 20);
    chk_ticks("stop_wd", s, 3, 1, 7, 13);
    chk("stop_wd_fin", fin_cyc - s, 18);
    chk("stop_wd_steps", int'(step_count), 3);

    // Period 0 clamps to 2 with immediate done
    launch(0, 4, 1, s);
    wait_fin("clamp", 30);
    chk("clamp_nticks", ticks.size(), 4);
    if (ticks.size() == 4) chk("clamp_tick3", ticks[3] - s, 7);
    chk("clamp_fin", fin_cyc - s, 9);

    // Wrap: 17 free-run steps, stop coincides with 17th done
    launch(2, 0, 1, s);
    wait_to(s + 34); stop = 1'b1; step(); stop = 1'b0;
    wait_fin("wrap", 20);
    chk("wrap_fin", fin_cyc - s, 35);
    chk("wrap_steps", int'(step_count), 1);

    // grid_error mid-run
    launch(6, 0, 3, s);
    wait_to(s + 8); grid_error = 1'b1; step(); grid_error = 1'b0;
    wait_fin("error", 20);
    chk_ticks("error", s, 2, 1, 7, 0);
    chk("error_fin", fin_cyc - s, 9);
    chk("error_fault", int'(fault), 1);
    chk("error_steps", int'(step_count), 1);

    // Reset during WAIT_DONE
    launch(6, 0, 4, s);
    wait_to(s + 3); reset_n = 1'b0; #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_fault", int'(fault), 0);
    step(); step(); reset_n = 1'b1; step();

    // Normal run after reset, with an ignored start mid-run
    launch(4, 2, 1, s);
    wait_to(s + 3); start = 1'b1; step(); start = 1'b0;
    wait_fin("ign_start", 30);
    chk_ticks("ign_start", s, 2, 1, 5, 0);
    chk("ign_start_fin", fin_cyc - s, 7);
    chk("ign_start_steps", int'(step_count), 2);

    // grid_done in IDLE leaves step_count alone
    g_man = 1'b1; step(); g_man = 1'b0; step();
    chk("idle_done_steps", int'(step_count), 2);

    // stop in IDLE, then start
    stop = 1'b1; step(); stop = 1'b0;
    launch(3, 1, 1, s);
    wait_fin("idle_stop", 20);
    chk_ticks("idle_stop", s, 1, 1, 0, 0);
    chk("idle_stop_fin", fin_cyc - s, 3);

    // start and stop together in IDLE: start wins
    cfg_period = PW'(3); cfg_num_steps = SW'(1); ticks.delete();
    s = cyc; start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    wait_fin("start_stop", 20);
    chk_ticks("start_stop", s, 1, 1, 0, 0);
    chk("start_stop_fin", fin_cyc - s, 3);
    chk("start_stop_steps", int'(step_count), 1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
